proc_lsu: RTL and testbench
===========================

# proc_lsu

Parametrised load/store unit between the execute stage and the data-memory port. It accepts one memory instruction at a time and generates byte enables and shifted write data. It assembles and sign/zero-extends load data per funct3. When enabled, it splits misaligned accesses that cross a word boundary into two bus transactions. It supersedes the fixed 32-bit, aligned-only load/store decode and adds XLEN=64 (LD/LWU/SD) and misaligned handling.

## Interface
- XLEN, 32: data width; 32 or 64. BYTES = XLEN/8.
- ADDR_W, 32: address width.
- MISALIGNED_SPLIT, 1: 1 = split boundary-crossing accesses into two transactions; 0 = report misaligned as error, no bus access.

- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  instruction request.
- req_ready  out  1  high only in IDLE.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV funct3 (B/H/W/D/BU/HU/WU).
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  XLEN  store data (rs2).
- req_rd  in  5  destination tag, echoed on response.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_rd  out  5  echoed tag.
- rsp_err  out  1  misaligned (split disabled), illegal funct3, or bus error.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accept.
- mem_we  out  1  write.
- mem_addr  out  ADDR_W  BYTES-aligned address.
- mem_be  out  BYTES  byte enables.
- mem_wdata  out  XLEN  lane-shifted write data.
- mem_rsp_valid  in  1  bus response; loads carry data, stores carry acknowledge.
- mem_rdata  in  XLEN  read data.
- mem_err  in  1  bus error, qualified by mem_rsp_valid.

## Operation
- Size: funct3[1:0] gives 1/2/4/8 bytes. Legal loads are 000,001,010,100,101; at XLEN=64 also 011 (LD) and 110 (LWU). Legal stores are 000,001,010; at XLEN=64 also 011. Any other funct3 is illegal.
- off = addr mod BYTES. An access is misaligned when addr mod size ≠ 0. It crosses a word boundary when off+size > BYTES.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - On req_valid, latch the request.
  - Illegal funct3, or misaligned with MISALIGNED_SPLIT=0: go to RESP with err=1 and no bus activity.
  - Otherwise go to REQ0.
- REQ0:
  - mem_addr = addr with low log2(BYTES) bits cleared.
  - mem_be = ((1<<size)-1)<<off, truncated to BYTES bits.
  - mem_wdata = wdata<<(8·off).
  - On mem_req_ready, go to WAIT0.
- WAIT0: on mem_rsp_valid, capture bytes off..BYTES-1. If mem_err, go to RESP with err=1. Otherwise go to REQ1 if the access crosses a boundary, else RESP.
- REQ1:
  - mem_addr = aligned addr + BYTES.
  - mem_be = remaining size-(BYTES-off) low bytes.
  - mem_wdata = wdata>>(8·(BYTES-off)).
  - On mem_req_ready, go to WAIT1.
- WAIT1: on mem_rsp_valid, capture the low bytes and set err from mem_err. Go to RESP.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- Load result: assemble size bytes, then sign-extend (B/H/W) or zero-extend (BU/HU/WU) to XLEN. On any error, rdata=0.
- A store erroring in its second half leaves its first half written; no rollback.
- mem_we = is_store in REQ0 and REQ1.
- mem_rsp_valid is ignored outside WAIT0/WAIT1.

## Timing
- Reset values (async, immediate): state IDLE; all outputs 0 except req_ready=1; latched fields 0.
- mem_req_valid, mem_addr, mem_be, mem_wdata and mem_we are registered. They stay stable from assertion until the mem_req_ready handshake.
- A bus response is accepted no earlier than the cycle after the request handshake.
- Latency, from the req handshake edge with zero bus wait:
  - Aligned access: REQ0 at +1, response at +2, rsp_valid at +3.
  - Split access: rsp_valid at +5.
  - Early error: rsp_valid at +1.
- Throughput: one instruction per 4 cycles aligned; no overlap.
- Reset mid-transaction abandons the access. A bus response arriving after reset is ignored.

## Test plan
- Aligned LW, addr 0x100, mem_rdata 0xDEADBEEF -> one request with be=1111, rsp_rdata=0xDEADBEEF, rsp_valid exactly 3 cycles after accept, rsp_rd echoed.
- LB then LBU at 0x103, word 0x80FFFFFF -> be=1000; rsp_rdata=0xFFFFFF80, then 0x00000080.
- Split LW at 0x102, mem[0x100]=0x44332211, mem[0x104]=0x88776655 -> requests (0x100, be 1100) then (0x104, be 0011); rsp_rdata=0x66554433, latency 5.
- Split SW at 0x103, data 0xAABBCCDD -> (0x100, be 1000, wdata 0xDD000000), then (0x104, be 0111, wdata 0x00AABBCC); rsp_rdata=0.
- MISALIGNED_SPLIT=0, LH at 0x101 -> no mem_req_valid; rsp_err=1 one cycle after accept. Illegal funct3 011 at XLEN=32 -> rsp_err=1 with no bus activity.
- Backpressure and reset:
  - mem_req_ready low for 5 cycles -> request outputs held stable.
  - mem_err on the first half of a split -> no second request, rsp_err=1.
  - rst_n low in WAIT0 -> all outputs reset immediately; a late mem_rsp_valid produces no rsp_valid.

Source files
------------

// File: rtl/proc_lsu_if.sv
// Load/store unit bundle: execute-side request/response plus data-memory port.
// The slave modport is the LSU's view; master is the core/memory environment.
interface proc_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic [4:0]        rsp_rd;
    logic              rsp_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BYTES-1:0]  mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_err;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        output mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata, mem_err
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        input  mem_req_valid, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata, mem_err
    );
endinterface

// File: rtl/proc_lsu.sv
// Load/store unit: one memory instruction at a time, byte-lane alignment,
// load extension, and optional two-transaction split of boundary-crossing accesses.
module proc_lsu #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit MISALIGNED_SPLIT = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    proc_lsu_if.slave  io_lsu
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_is_store;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic [4:0]          r_rd;
    logic                r_err;
    logic [XLEN-1:0]     r_data;
    logic                r_mem_valid, w_mem_valid_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [BYTES-1:0]    r_mem_be, w_mem_be_nxt;
    logic [XLEN-1:0]     r_mem_wdata, w_mem_wdata_nxt;

    logic                w_src_store;
    logic [2:0]          w_src_f3;
    logic [ADDR_W-1:0]   w_src_addr;
    logic [XLEN-1:0]     w_src_wdata;
    logic [OFF_W-1:0]    w_off;
    logic [OFF_W:0]      w_hi_bytes;
    logic [3:0]          w_size;
    logic                w_cross;
    logic                w_misal;
    logic [7:0]          w_mask_base;
    logic [2*BYTES-1:0]  w_be_sh;
    logic [2*XLEN-1:0]   w_wd_sh;
    logic [ADDR_W-1:0]   w_addr_al;

    function automatic logic f_legal(input logic st, input logic [2:0] f3);
        logic ok;
        if (st)
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 ((XLEN == 64) && (f3 == 3'b011));
        else
            ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101) ||
                 ((XLEN == 64) && ((f3 == 3'b011) || (f3 == 3'b110)));
        return ok;
    endfunction

    // Keep the low 'size' bytes, fill the rest with the sign bit or zero.
    function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] res;
        logic            fill;
        int              n;
        n = 1 << f3[1:0];
        if (n > BYTES) n = BYTES;
        fill = f3[2] ? 1'b0 : d[8*n-1];
        for (int i = 0; i < BYTES; i++)
            res[8*i +: 8] = (i < n) ? d[8*i +: 8] : {8{fill}};
        return res;
    endfunction

    // Live request fields while idle so the first bus beat is ready at the accept edge.
    always_comb begin
        w_src_store = (r_state == S_IDLE) ? io_lsu.req_is_store : r_is_store;
        w_src_f3    = (r_state == S_IDLE) ? io_lsu.req_funct3   : r_funct3;
        w_src_addr  = (r_state == S_IDLE) ? io_lsu.req_addr     : r_addr;
        w_src_wdata = (r_state == S_IDLE) ? io_lsu.req_wdata    : r_wdata;
    end

    assign w_off       = w_src_addr[OFF_W-1:0];
    assign w_hi_bytes  = (OFF_W+1)'(BYTES) - {1'b0, w_off};
    assign w_size      = 4'd1 << w_src_f3[1:0];
    assign w_cross     = ({1'b0, 4'(w_off)} + {1'b0, w_size}) > 5'(BYTES);
    assign w_misal     = (w_src_addr[2:0] & 3'(w_size - 4'd1)) != 3'b000;
    assign w_mask_base = 8'((9'd1 << w_size) - 9'd1);
    assign w_be_sh     = (2*BYTES)'(w_mask_base) << w_off;
    assign w_wd_sh     = {{XLEN{1'b0}}, w_src_wdata} << {w_off, 3'b000};
    assign w_addr_al   = {w_src_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_valid_nxt = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_be_nxt    = '0;
        w_mem_wdata_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (io_lsu.req_valid) begin
                    if (!f_legal(io_lsu.req_is_store, io_lsu.req_funct3) ||
                        (w_misal && !MISALIGNED_SPLIT))
                        w_state_nxt = S_RESP;
                    else
                        w_state_nxt = S_REQ0;
                end
            end
            S_REQ0:  if (io_lsu.mem_req_ready) w_state_nxt = S_WAIT0;
            S_WAIT0: begin
                if (io_lsu.mem_rsp_valid)
                    w_state_nxt = (io_lsu.mem_err || !w_cross) ? S_RESP : S_REQ1;
            end
            S_REQ1:  if (io_lsu.mem_req_ready) w_state_nxt = S_WAIT1;
            S_WAIT1: if (io_lsu.mem_rsp_valid) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Bus outputs are registered; they hold while waiting in REQ0/REQ1.
        if (w_state_nxt == S_REQ0) begin
            w_mem_valid_nxt = 1'b1;
            w_mem_we_nxt    = w_src_store;
            w_mem_addr_nxt  = w_addr_al;
            w_mem_be_nxt    = w_be_sh[BYTES-1:0];
            w_mem_wdata_nxt = w_wd_sh[XLEN-1:0];
        end else if (w_state_nxt == S_REQ1) begin
            w_mem_valid_nxt = 1'b1;
            w_mem_we_nxt    = w_src_store;
            w_mem_addr_nxt  = w_addr_al + ADDR_W'(BYTES);
            w_mem_be_nxt    = w_be_sh[2*BYTES-1:BYTES];
            w_mem_wdata_nxt = w_wd_sh[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_is_store  <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= '0;
            r_err       <= 1'b0;
            r_data      <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            case (r_state)
                S_IDLE: begin
                    if (io_lsu.req_valid) begin
                        r_is_store <= io_lsu.req_is_store;
                        r_funct3   <= io_lsu.req_funct3;
                        r_addr     <= io_lsu.req_addr;
                        r_wdata    <= io_lsu.req_wdata;
                        r_rd       <= io_lsu.req_rd;
                        r_err      <= (w_state_nxt == S_RESP);
                        r_data     <= '0;
                    end
                end
                S_WAIT0: begin
                    if (io_lsu.mem_rsp_valid) begin
                        r_data <= io_lsu.mem_rdata >> {w_off, 3'b000};
                        r_err  <= io_lsu.mem_err;
                    end
                end
                S_WAIT1: begin
                    if (io_lsu.mem_rsp_valid) begin
                        r_data <= r_data | (io_lsu.mem_rdata << {w_hi_bytes, 3'b000});
                        r_err  <= io_lsu.mem_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_lsu.req_ready     = (r_state == S_IDLE);
    assign io_lsu.rsp_valid     = (r_state == S_RESP);
    assign io_lsu.rsp_err       = (r_state == S_RESP) && r_err;
    assign io_lsu.rsp_rd        = (r_state == S_RESP) ? r_rd : 5'd0;
    assign io_lsu.rsp_rdata     = ((r_state == S_RESP) && !r_err && !r_is_store) ?
                                  f_extend(r_data, r_funct3) : '0;
    assign io_lsu.mem_req_valid = r_mem_valid;
    assign io_lsu.mem_we        = r_mem_we;
    assign io_lsu.mem_addr      = r_mem_addr;
    assign io_lsu.mem_be        = r_mem_be;
    assign io_lsu.mem_wdata     = r_mem_wdata;
endmodule

// File: tb/tb_proc_lsu.sv
// Directed bench for proc_lsu: split-enabled instance with a memory responder,
// plus a split-disabled instance for the misaligned-error path.
`timescale 1ns/1ps
module tb_proc_lsu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    proc_lsu_if #(.XLEN(32), .ADDR_W(32)) ifa ();
    proc_lsu_if #(.XLEN(32), .ADDR_W(32)) ifb ();

    proc_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGNED_SPLIT(1'b1)) u_lsu_a (
        .i_clk(clk), .i_rst_n(rst_n), .io_lsu(ifa.slave));
    proc_lsu #(.XLEN(32), .ADDR_W(32), .MISALIGNED_SPLIT(1'b0)) u_lsu_b (
        .i_clk(clk), .i_rst_n(rst_n), .io_lsu(ifb.slave));

    logic        sel = 1'b0;
    logic        rq_valid = 1'b0;
    logic        rq_store = 1'b0;
    logic [2:0]  rq_f3 = '0;
    logic [31:0] rq_addr = '0;
    logic [31:0] rq_wdata = '0;
    logic [4:0]  rq_rd = '0;

    assign ifa.req_valid = rq_valid & ~sel;
    assign ifb.req_valid = rq_valid & sel;
    assign ifa.req_is_store = rq_store;
    assign ifb.req_is_store = rq_store;
    assign ifa.req_funct3 = rq_f3;
    assign ifb.req_funct3 = rq_f3;
    assign ifa.req_addr = rq_addr;
    assign ifb.req_addr = rq_addr;
    assign ifa.req_wdata = rq_wdata;
    assign ifb.req_wdata = rq_wdata;
    assign ifa.req_rd = rq_rd;
    assign ifb.req_rd = rq_rd;
    assign ifb.mem_req_ready = 1'b1;
    assign ifb.mem_rsp_valid = 1'b0;
    assign ifb.mem_rdata = '0;
    assign ifb.mem_err = 1'b0;

    logic        s_rsp_valid, s_rsp_err, s_req_ready;
    logic [31:0] s_rsp_rdata;
    logic [4:0]  s_rsp_rd;
    assign s_rsp_valid = sel ? ifb.rsp_valid : ifa.rsp_valid;
    assign s_rsp_err   = sel ? ifb.rsp_err   : ifa.rsp_err;
    assign s_req_ready = sel ? ifb.req_ready : ifa.req_ready;
    assign s_rsp_rdata = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign s_rsp_rd    = sel ? ifb.rsp_rd    : ifa.rsp_rd;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } bus_req_t;

    bus_req_t    log_q[$];
    logic [31:0] mem [0:15];
    int          hold = 0;
    int          rsp_delay = 0;
    logic        err_next = 1'b0;
    int          stall = 0;
    int          stall_total = 0;
    int          unstable = 0;
    int          rsp_cnt = 0;
    int          b_mem_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) if (ifb.mem_req_valid) b_mem_cnt++;

    // Memory responder for instance A: optional stall and response delay.
    initial begin
        int       pend;
        bus_req_t snap;
        bus_req_t cur;
        logic [31:0] p_addr;
        logic        p_err;
        pend = 0; p_addr = '0; p_err = 1'b0;
        snap = '{addr: '0, be: '0, wdata: '0, we: 1'b0};
        ifa.mem_req_ready = 1'b1;
        ifa.mem_rsp_valid = 1'b0;
        ifa.mem_rdata = '0;
        ifa.mem_err = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.mem_req_valid) begin
                cur = '{addr: ifa.mem_addr, be: ifa.mem_be, wdata: ifa.mem_wdata, we: ifa.mem_we};
                if (ifa.mem_req_ready) begin
                    log_q.push_back(cur);
                    pend = 1 + rsp_delay;
                    p_addr = ifa.mem_addr;
                    p_err = err_next;
                    err_next = 1'b0;
                    stall = 0;
                end else begin
                    if (stall == 0) snap = cur;
                    else if (cur != snap) unstable++;
                    stall++;
                    stall_total++;
                end
            end
            @(posedge clk);
            #1;
            ifa.mem_rsp_valid = 1'b0;
            ifa.mem_err = 1'b0;
            ifa.mem_rdata = '0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    ifa.mem_rsp_valid = 1'b1;
                    ifa.mem_rdata = mem[p_addr[5:2]];
                    ifa.mem_err = p_err;
                    rsp_cnt++;
                end
            end
            ifa.mem_req_ready = (hold == 0) || (stall >= hold);
        end
    end

    int          got_lat;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [4:0]  got_rd;

    task automatic do_req(input logic s, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        @(posedge clk);
        #1;
        sel = s; rq_valid = 1'b1; rq_store = st; rq_f3 = f3;
        rq_addr = a; rq_wdata = wd; rq_rd = rd;
        @(negedge clk);
        chk("req_ready", s_req_ready, 1'b1);
        @(posedge clk);
        #1;
        rq_valid = 1'b0;
        got_lat = 0; got_rdata = '0; got_err = 1'b0; got_rd = '0;
        for (int c = 1; c <= 40 && got_lat == 0; c++) begin
            @(negedge clk);
            if (s_rsp_valid) begin
                got_lat = c; got_rdata = s_rsp_rdata; got_err = s_rsp_err; got_rd = s_rsp_rd;
            end
        end
        if (got_lat == 0) chk("rsp_timeout", 1'b0, 1'b1);
        else begin
            @(negedge clk);
            chk("rsp_pulse", s_rsp_valid, 1'b0);
        end
    endtask

    initial begin
        int late;
        int rc0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", ifa.req_ready, 1'b1);
        chk("rst_rsp_valid", ifa.rsp_valid, 1'b0);
        chk("rst_mem_valid", ifa.mem_req_valid, 1'b0);
        chk("rst_mem_be", ifa.mem_be, 4'h0);
        chk("rst_rsp_rdata", ifa.rsp_rdata, 32'h0);

        // Aligned LW
        mem[0] = 32'hDEADBEEF; log_q.delete();
        do_req(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5);
        chk("lw_nreq", log_q.size(), 1);
        chk("lw_addr", log_q[0].addr, 32'h100);
        chk("lw_be", log_q[0].be, 4'b1111);
        chk("lw_we", log_q[0].we, 1'b0);
        chk("lw_rdata", got_rdata, 32'hDEADBEEF);
        chk("lw_lat", got_lat, 3);
        chk("lw_rd", got_rd, 5'd5);
        chk("lw_err", got_err, 1'b0);

        // LB / LBU of the top byte
        mem[0] = 32'h80FFFFFF; log_q.delete();
        do_req(1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6);
        chk("lb_be", log_q[0].be, 4'b1000);
        chk("lb_rdata", got_rdata, 32'hFFFFFF80);
        do_req(1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7);
        chk("lbu_rdata", got_rdata, 32'h00000080);

        // LH sign extension in the upper half
        mem[0] = 32'h80017F00;
        do_req(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 5'd8);
        chk("lh_rdata", got_rdata, 32'hFFFF8001);
        do_req(1'b0, 1'b0, 3'b101, 32'h102, 32'h0, 5'd8);
        chk("lhu_rdata", got_rdata, 32'h00008001);

        // Split LW across words
        mem[0] = 32'h44332211; mem[1] = 32'h88776655; log_q.delete();
        do_req(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 5'd9);
        chk("slw_nreq", log_q.size(), 2);
        chk("slw_a0", log_q[0].addr, 32'h100);
        chk("slw_be0", log_q[0].be, 4'b1100);
        chk("slw_a1", log_q[1].addr, 32'h104);
        chk("slw_be1", log_q[1].be, 4'b0011);
        chk("slw_rdata", got_rdata, 32'h66554433);
        chk("slw_lat", got_lat, 5);

        // Split SW across words
        log_q.delete();
        do_req(1'b0, 1'b1, 3'b010, 32'h103, 32'hAABBCCDD, 5'd10);
        chk("ssw_nreq", log_q.size(), 2);
        chk("ssw_a0", log_q[0].addr, 32'h100);
        chk("ssw_be0", log_q[0].be, 4'b1000);
        chk("ssw_wd0", log_q[0].wdata, 32'hDD000000);
        chk("ssw_we0", log_q[0].we, 1'b1);
        chk("ssw_a1", log_q[1].addr, 32'h104);
        chk("ssw_be1", log_q[1].be, 4'b0111);
        chk("ssw_wd1", log_q[1].wdata, 32'h00AABBCC);
        chk("ssw_rdata", got_rdata, 32'h0);
        chk("ssw_lat", got_lat, 5);

        // Misaligned SH inside one word, and SB lane shift
        log_q.delete();
        do_req(1'b0, 1'b1, 3'b001, 32'h101, 32'h0000BEEF, 5'd11);
        chk("sh_nreq", log_q.size(), 1);
        chk("sh_be", log_q[0].be, 4'b0110);
        chk("sh_wd", log_q[0].wdata, 32'h00BEEF00);
        chk("sh_lat", got_lat, 3);
        log_q.delete();
        do_req(1'b0, 1'b1, 3'b000, 32'h102, 32'h12345678, 5'd12);
        chk("sb_be", log_q[0].be, 4'b0100);
        chk("sb_wd", log_q[0].wdata, 32'h56780000);

        // Split disabled: misaligned LH is an early error
        do_req(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 5'd13);
        chk("nosplit_err", got_err, 1'b1);
        chk("nosplit_lat", got_lat, 1);
        chk("nosplit_rdata", got_rdata, 32'h0);
        chk("nosplit_rd", got_rd, 5'd13);
        chk("nosplit_nobus", b_mem_cnt, 0);

        // Illegal funct3 at XLEN=32
        log_q.delete();
        do_req(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 5'd14);
        chk("ill_ld_err", got_err, 1'b1);
        chk("ill_ld_lat", got_lat, 1);
        do_req(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 5'd15);
        chk("ill_st_err", got_err, 1'b1);
        chk("ill_nobus", log_q.size(), 0);

        // Bus backpressure for 5 cycles
        hold = 5; stall_total = 0; unstable = 0; log_q.delete();
        do_req(1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 5'd16);
        hold = 0;
        chk("bp_stalls", stall_total, 5);
        chk("bp_stable", unstable, 0);
        chk("bp_addr", log_q[0].addr, 32'h104);
        chk("bp_rdata", got_rdata, 32'h88776655);
        chk("bp_lat", got_lat, 8);

        // Bus error on first half of a split
        err_next = 1'b1; log_q.delete();
        do_req(1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 5'd17);
        chk("berr_nreq", log_q.size(), 1);
        chk("berr_err", got_err, 1'b1);
        chk("berr_rdata", got_rdata, 32'h0);
        chk("berr_lat", got_lat, 3);

        // Reset while waiting for the response
        rsp_delay = 2; mem[0] = 32'h12345678; rc0 = rsp_cnt;
        @(posedge clk);
        #1 sel = 1'b0; rq_valid = 1'b1; rq_store = 1'b0; rq_f3 = 3'b010;
        rq_addr = 32'h100; rq_rd = 5'd18;
        @(posedge clk);
        #1 rq_valid = 1'b0;
        @(posedge clk);
        #1 chk("rst_busy", ifa.req_ready, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req_ready", ifa.req_ready, 1'b1);
        chk("arst_rsp_valid", ifa.rsp_valid, 1'b0);
        chk("arst_mem_valid", ifa.mem_req_valid, 1'b0);
        chk("arst_mem_be", ifa.mem_be, 4'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        late = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.rsp_valid) late++;
        end
        rsp_delay = 0;
        chk("late_rsp_sent", rsp_cnt - rc0, 1);
        chk("late_rsp_ignored", late, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
